ibi_ctrl: RTL

- Target-initiated In-Band Interrupt engine of the I3C controller. Sits directly downstream of the main control unit.
- Started by the MCU's IBI enable. Captures the arbitrated target address and looks it up in the Device Address Table (DAT) in the register file.
- ACKs or NACKs the IBI. When a payload is expected, hands the bus to the SDR engine through the payload handshake. Reports completion back to the MCU.

---
 rtl/ibi_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ibi_ctrl.sv
// ibi_ctrl: target-initiated In-Band Interrupt engine.
// Captures the arbitrated address, walks the Device Address Table with a
// pipelined read/compare, drives ACK/NACK, optionally hands off to the SDR
// payload path, and reports completion to the MCU.
module ibi_ctrl #(
   parameter int NUM_DEV  = 8,
   parameter int DAT_BASE = 'h40,
   parameter int ADDR_W   = 8
) (
   input  logic              i_ibi_clk,
   input  logic              i_ibi_rst_n,
   input  logic              i_ibi_en,
   input  logic              i_ibi_rx_done,
   input  logic [6:0]        i_ibi_rx_addr,
   input  logic              i_ibi_rx_rnw,
   input  logic [7:0]        i_ibi_regf_data,
   input  logic              i_ibi_cfg_payload,
   input  logic              i_ibi_tx_done,
   input  logic              i_ibi_payload_done,
   output logic              o_ibi_rx_en,
   output logic              o_ibi_tx_en,
   output logic [2:0]        o_ibi_tx_mode,
   output logic              o_ibi_regf_rd_en,
   output logic [ADDR_W-1:0] o_ibi_regf_addr,
   output logic              o_ibi_payload_en,
   output logic              o_ibi_done,
   output logic [1:0]        o_ibi_status,
   output logic [6:0]        o_ibi_addr
);

   localparam int IW = $clog2(NUM_DEV + 1);

   localparam logic [2:0] MODE_ACK  = 3'b001;
   localparam logic [2:0] MODE_NACK = 3'b010;

   localparam logic [1:0] ST_NONE = 2'b00;
   localparam logic [1:0] ST_ACC  = 2'b01;
   localparam logic [1:0] ST_REJ  = 2'b10;
   localparam logic [1:0] ST_INV  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_CHECK, S_ACK, S_NACK, S_PAYLOAD, S_DONE
   } state_e;

   state_e            state_q;
   logic [IW-1:0]     idx_q;      // next DAT entry to read
   logic [IW-1:0]     idx_d;
   logic [IW-1:0]     cidx_q;     // entry whose data is on i_ibi_regf_data
   logic              pend_q;     // a read was issued last cycle
   logic              rx_en_q, tx_en_q, rd_en_q, payload_en_q, done_q;
   logic [2:0]        tx_mode_q;
   logic [ADDR_W-1:0] regf_addr_q;
   logic [1:0]        status_q;
   logic [6:0]        addr_q;
   logic              hit, last;

   assign idx_d = idx_q + IW'(1);
   assign hit   = (i_ibi_regf_data[6:0] == addr_q);
   assign last  = (cidx_q == IW'(NUM_DEV - 1));

   // Single registered FSM: every output is a flop updated with the state.
   always_ff @(posedge i_ibi_clk or negedge i_ibi_rst_n) begin
      if (!i_ibi_rst_n) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         cidx_q       <= '0;
         pend_q       <= 1'b0;
         rx_en_q      <= 1'b0;
         tx_en_q      <= 1'b0;
         tx_mode_q    <= 3'b000;
         rd_en_q      <= 1'b0;
         regf_addr_q  <= '0;
         payload_en_q <= 1'b0;
         done_q       <= 1'b0;
         status_q     <= ST_NONE;
         addr_q       <= '0;
      end else begin
         done_q <= 1'b0;
         pend_q <= rd_en_q;
         cidx_q <= idx_q - IW'(1);
         if (!i_ibi_en && state_q != S_DONE) begin
            // Abort: drop every strobe, keep the last result visible.
            state_q      <= S_IDLE;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            rx_en_q      <= 1'b0;
            tx_en_q      <= 1'b0;
            tx_mode_q    <= 3'b000;
            rd_en_q      <= 1'b0;
            payload_en_q <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  state_q <= S_ADDR;
                  rx_en_q <= 1'b1;
               end
               S_ADDR: begin
                  if (i_ibi_rx_done) begin
                     addr_q  <= i_ibi_rx_addr;
                     rx_en_q <= 1'b0;
                     if (!i_ibi_rx_rnw) begin
                        // Write-direction (incl. hot-join) is never a valid IBI.
                        status_q  <= ST_INV;
                        state_q   <= S_NACK;
                        tx_en_q   <= 1'b1;
                        tx_mode_q <= MODE_NACK;
                     end else begin
                        status_q    <= ST_NONE;
                        state_q     <= S_CHECK;
                        rd_en_q     <= 1'b1;
                        regf_addr_q <= ADDR_W'(DAT_BASE);
                        idx_q       <= IW'(1);
                     end
                  end
               end
               S_CHECK: begin
                  if (pend_q && (hit || last)) begin
                     rd_en_q   <= 1'b0;
                     idx_q     <= '0;
                     tx_en_q   <= 1'b1;
                     if (hit && i_ibi_regf_data[7]) begin
                        status_q  <= ST_ACC;
                        state_q   <= S_ACK;
                        tx_mode_q <= MODE_ACK;
                     end else begin
                        status_q  <= hit ? ST_REJ : ST_INV;
                        state_q   <= S_NACK;
                        tx_mode_q <= MODE_NACK;
                     end
                  end else if (idx_q < IW'(NUM_DEV)) begin
                     // Keep one read in flight ahead of the compare.
                     rd_en_q     <= 1'b1;
                     regf_addr_q <= ADDR_W'(DAT_BASE) + ADDR_W'(idx_q);
                     idx_q       <= idx_d;
                  end else begin
                     rd_en_q <= 1'b0;
                  end
               end
               S_ACK: begin
                  if (i_ibi_tx_done) begin
                     tx_en_q   <= 1'b0;
                     tx_mode_q <= 3'b000;
                     if (i_ibi_cfg_payload) begin
                        state_q      <= S_PAYLOAD;
                        payload_en_q <= 1'b1;
                     end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                     end
                  end
               end
               S_NACK: begin
                  if (i_ibi_tx_done) begin
                     tx_en_q   <= 1'b0;
                     tx_mode_q <= 3'b000;
                     state_q   <= S_DONE;
                     done_q    <= 1'b1;
                  end
               end
               S_PAYLOAD: begin
                  if (i_ibi_payload_done) begin
                     payload_en_q <= 1'b0;
                     state_q      <= S_DONE;
                     done_q       <= 1'b1;
                  end
               end
               S_DONE: state_q <= S_IDLE;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign o_ibi_rx_en      = rx_en_q;
   assign o_ibi_tx_en      = tx_en_q;
   assign o_ibi_tx_mode    = tx_mode_q;
   assign o_ibi_regf_rd_en = rd_en_q;
   assign o_ibi_regf_addr  = regf_addr_q;
   assign o_ibi_payload_en = payload_en_q;
   assign o_ibi_done       = done_q;
   assign o_ibi_status     = status_q;
   assign o_ibi_addr       = addr_q;

endmodule
